// File: rtl/dmem_lsu_arbiter_pkg.sv
// Shared types for the data-memory load/store arbiter.
// Size codes, FSM states and requester port indices.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/dmem_lsu_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
// The slave modport is the arbiter; master is the requester/memory side.
interface dmem_lsu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [3:0]         req_size;
  logic [1:0]         req_unsigned;
  logic [2*WIDTH-1:0] req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic [1:0]         rsp_valid;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;
  logic [WIDTH-1:0]   mem_addr;
  logic               mem_wr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu_arbiter_lane_fmt.sv
// Little-endian lane extract (loads) and lane merge (sub-word stores).
// Word size passes the memory word / store data through untouched.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       off,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] sdata
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = word[{off, 3'b000} +: 8];
    h     = word[{off[1], 4'b0000} +: 16];
    ldata = word;
    sdata = wdata;
    unique case (size)
      SZ_B: begin
        ldata = {{(WIDTH-8){b[7] & ~uns}}, b};
        sdata = word;
        sdata[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ldata = {{(WIDTH-16){h[15] & ~uns}}, h};
        sdata = word;
        sdata[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_lsu_arbiter.sv
// Round-robin two-port load/store controller for a word-only
// single-port synchronous-read data memory, with RMW for sub-words.
module dmem_lsu_arbiter
  import dmem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  dmem_lsu_arbiter_if.slave bus,
  output logic              busy
);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MEM_WORDS);

  state_t           state, nxt;
  logic             port, last_grant;
  logic             we, uns, err_q;
  logic [1:0]       size;
  logic [WIDTH-1:0] addr, wbuf, rdata_q;

  logic [1:0]       gnt;
  logic             sel, accept, a_bad, a_we, a_uns;
  logic [1:0]       a_size;
  logic [WIDTH-1:0] a_addr, a_wdata;
  logic [WIDTH-1:0] ld_val, st_val;

  always_comb begin
    gnt = '0;
    if (state == S_IDLE) begin
      unique case (1'b1)
        bus.req_valid == 2'b11:
          gnt = last_grant ? 2'b01 : 2'b10;
        bus.req_valid == 2'b01:
          gnt[PORT_CORE] = 1'b1;
        bus.req_valid == 2'b10:
          gnt[PORT_DMA] = 1'b1;
        default: ;
      endcase
    end
  end

  assign sel     = gnt[PORT_DMA];
  assign accept  = |gnt;
  assign a_we    = bus.req_we[sel];
  assign a_uns   = bus.req_unsigned[sel];
  assign a_size  = sel ? bus.req_size[3:2]
                       : bus.req_size[1:0];
  assign a_addr  = sel ? bus.req_addr[2*WIDTH-1:WIDTH]
                       : bus.req_addr[WIDTH-1:0];
  assign a_wdata = sel ? bus.req_wdata[2*WIDTH-1:WIDTH]
                       : bus.req_wdata[WIDTH-1:0];

  assign a_bad = (a_size == SZ_X)
              | ((a_size == SZ_H) & a_addr[0])
              | ((a_size == SZ_W) & (|a_addr[1:0]))
              | ({2'b00, a_addr[WIDTH-1:2]} >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (a_bad)
            nxt = S_RESP;
          else if (a_we && a_size == SZ_W)
            nxt = S_WR;
          else
            nxt = S_RD;
        end
      end
      S_RD:    nxt = S_MERGE;
      S_MERGE: nxt = we ? S_WR : S_RESP;
      S_WR:    nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port       <= 1'b0;
      last_grant <= 1'b1;
      we         <= 1'b0;
      uns        <= 1'b0;
      size       <= SZ_B;
      addr       <= '0;
      wbuf       <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        port       <= sel;
        last_grant <= sel;
        we         <= a_we;
        uns        <= a_uns;
        size       <= a_size;
        addr       <= a_addr;
        wbuf       <= a_wdata;
        err_q      <= a_bad;
      end else if (state == S_RESP) begin
        err_q <= 1'b0;
      end
      // RMW: the merged word replaces the raw store data
      if (state == S_MERGE && we)
        wbuf <= st_val;
      rdata_q <= (state == S_MERGE && !we) ? ld_val : '0;
    end
  end

  dmem_lane_fmt #(.WIDTH(WIDTH)) u_fmt (
    .word  (bus.mem_rdata),
    .off   (addr[1:0]),
    .size  (size),
    .uns   (uns),
    .wdata (wbuf),
    .ldata (ld_val),
    .sdata (st_val)
  );

  always_comb begin
    bus.rsp_valid = '0;
    if (state == S_RESP)
      bus.rsp_valid[port] = 1'b1;
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_wr    = (state == S_WR);
  assign bus.mem_wdata = (state == S_WR) ? wbuf : '0;
  assign bus.mem_addr  = (state == S_RD || state == S_WR)
                       ? {2'b00, addr[WIDTH-1:2]} : '0;
  assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_dmem_lsu_arbiter.sv
// Scoreboard bench for dmem_lsu_arbiter with a behavioural
// synchronous-read memory and directed load/store vectors.
module tb_dmem_lsu_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic init = 1'b1;

  dmem_lsu_arbiter_if #(.WIDTH(32)) bus();

  dmem_lsu_arbiter #(
    .WIDTH(32),
    .MEM_WORDS(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [31:0] mem [1024];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= 32'hA500_0000 | i;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[9:0]];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (bus.rsp_valid[p]) begin
          exp_t e;
          bit   have;
          have = 1'b0;
          if (p == 0 && q0.size() > 0) begin
            e = q0.pop_front(); have = 1'b1;
          end else if (p == 1 && q1.size() > 0) begin
            e = q1.pop_front(); have = 1'b1;
          end
          if (!have) begin
            tests++; fails++;
            $display("FAIL rsp_unexpected p%0d: got rsp_valid=%b expected none",
                     p, bus.rsp_valid);
          end else begin
            chk($sformatf("rsp_rdata p%0d", p), bus.rsp_rdata, e.rd);
            chk($sformatf("rsp_err p%0d", p), 32'(bus.rsp_err), 32'(e.err));
            chk($sformatf("rsp_cycle p%0d", p), cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic issue(input int p, input bit w,
                       input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input bit eerr,
                       input bit track, output int acc);
    int   n;
    int   lat;
    exp_t e;
    bus.req_we[p]            = w;
    bus.req_size[2*p +: 2]   = sz;
    bus.req_unsigned[p]      = u;
    bus.req_addr[32*p +: 32] = a;
    bus.req_wdata[32*p +: 32] = d;
    bus.req_valid[p]         = 1'b1;
    acc = -1;
    n = 0;
    #1;
    while (!bus.req_ready[p] && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.req_ready[p]) begin
      tests++; fails++;
      $display("FAIL accept_timeout p%0d: got req_ready=%b expected grant",
               p, bus.req_ready);
      bus.req_valid[p] = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    grant_log.push_back(p);
    lat = eerr ? 1 : (w && sz == SZ_W) ? 2 : w ? 4 : 3;
    e.rd  = erd;
    e.err = eerr;
    e.cyc = acc + lat;
    if (track) begin
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    bus.req_valid[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_size = '0;
    bus.req_unsigned = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    init = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    fork
      begin
        issue(0, 0, SZ_W, 0, 32'h40, 0, 32'hA500_0010, 0, 1, a0);
        issue(0, 0, SZ_W, 0, 32'h48, 0, 32'hA500_0012, 0, 1, a0);
      end
      begin
        issue(1, 0, SZ_W, 0, 32'h44, 0, 32'hA500_0011, 0, 1, a1);
        issue(1, 0, SZ_W, 0, 32'h4C, 0, 32'hA500_0013, 0, 1, a1);
      end
      begin
        #2;
        chk("ready_both_valid", 32'(bus.req_ready), 32'h1);
      end
    join
    chk("grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("grant0", grant_log[0], 0);
      chk("grant1", grant_log[1], 1);
      chk("grant2", grant_log[2], 0);
      chk("grant3", grant_log[3], 1);
    end
    repeat (4) @(negedge clk);

    issue(0, 1, SZ_W, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 1, a0);
    #1;
    chk("sw_mem_wr", 32'(bus.mem_wr), 1);
    chk("sw_mem_addr", bus.mem_addr, 4);
    chk("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    issue(0, 0, SZ_W, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 1, a0);

    @(negedge clk);
    issue(0, 1, SZ_B, 0, 32'h11, 32'hFFFF_FF55, 0, 0, 1, a0);
    #1;
    chk("sb_rd_mem_wr", 32'(bus.mem_wr), 0);
    chk("sb_rd_mem_addr", bus.mem_addr, 4);
    @(negedge clk); #1;
    chk("sb_merge_mem_addr", bus.mem_addr, 0);
    @(negedge clk); #1;
    chk("sb_wr_mem_wr", 32'(bus.mem_wr), 1);
    chk("sb_wr_mem_addr", bus.mem_addr, 4);
    chk("sb_wr_mem_wdata", bus.mem_wdata, 32'hDEAD_55EF);

    @(negedge clk);
    issue(0, 0, SZ_B, 0, 32'h11, 0, 32'h0000_0055, 0, 1, a0);
    issue(0, 0, SZ_B, 0, 32'h13, 0, 32'hFFFF_FFDE, 0, 1, a0);
    issue(0, 0, SZ_B, 1, 32'h13, 0, 32'h0000_00DE, 0, 1, a0);
    issue(0, 0, SZ_H, 0, 32'h12, 0, 32'hFFFF_DEAD, 0, 1, a0);
    issue(0, 0, SZ_H, 1, 32'h10, 0, 32'h0000_55EF, 0, 1, a0);

    issue(0, 0, SZ_H, 0, 32'h13, 0, 0, 1, 1, a0);
    #1;
    chk("err_no_mem_wr", 32'(bus.mem_wr), 0);
    chk("err_busy", 32'(busy), 1);
    @(negedge clk);
    issue(0, 0, SZ_W, 0, 32'h1000, 0, 0, 1, 1, a0);
    issue(0, 0, SZ_X, 0, 32'h20, 0, 0, 1, 1, a0);
    issue(0, 0, SZ_W, 0, 32'h12, 0, 0, 1, 1, a0);
    issue(0, 0, SZ_W, 0, 32'hFFC, 0, 32'hA500_03FF, 0, 1, a0);

    issue(1, 1, SZ_H, 0, 32'h32, 32'hABCD_1234, 0, 0, 1, a0);
    issue(1, 0, SZ_W, 0, 32'h30, 0, 32'h1234_000C, 0, 1, a0);

    repeat (3) @(negedge clk);
    issue(0, 1, SZ_H, 0, 32'h22, 32'h0000_7777, 0, 0, 0, a0);
    @(negedge clk); #1;
    chk("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mem_wr", 32'(bus.mem_wr), 0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    issue(0, 0, SZ_W, 0, 32'h20, 0, 32'hA500_0008, 0, 1, a0);

    @(negedge clk);
    issue(1, 1, SZ_W, 0, 32'h50, 32'h1111_1111, 0, 0, 1, a0);
    issue(1, 1, SZ_W, 0, 32'h54, 32'h2222_2222, 0, 0, 1, a1);
    chk("b2b_accept_gap", a1 - a0, 3);
    issue(1, 0, SZ_W, 0, 32'h54, 0, 32'h2222_2222, 0, 1, a0);
    issue(1, 0, SZ_W, 0, 32'h50, 0, 32'h1111_1111, 0, 1, a0);

    repeat (6) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_lsu_arbiter.md
Name: dmem_lsu_arbiter

Overview:
Two-requester load/store controller in front of the word-organised, single-port, synchronous-read data memory. Port 0 serves the core's load/store unit and port 1 the DMA/debug path, arbitrated round-robin. The block converts byte addresses to word indices and checks alignment and range. It sign- or zero-extends sub-word loads and sequences read-modify-write for byte and halfword stores. The memory itself only supports full-word access.

Parameters:
WIDTH, 32, data and address width.
MEM_WORDS, 1024, memory depth in words; word index must be < MEM_WORDS.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-port request valid, bit n = port n
req_ready  out  2  per-port accept; high only in IDLE, for the granted port only
req_we  in  2  1 = store, 0 = load
req_size  in  4  2 bits per port: 0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  2  load zero-extend when 1
req_addr  in  2*WIDTH  byte address; port n is at [n*WIDTH +: WIDTH]
req_wdata  in  2*WIDTH  store data, right-justified
rsp_valid  out  2  one-cycle response pulse per port
rsp_rdata  out  WIDTH  load result; valid with rsp_valid, 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range or illegal size; valid with rsp_valid
mem_addr  out  WIDTH  word index, equal to addr[WIDTH-1:2] zero-extended
mem_wr  out  1  memory write enable
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data; valid the cycle after mem_addr is presented with mem_wr=0
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, last_grant=1 (so port 0 wins first), and rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_wdata, mem_addr all 0.
- One transaction in flight at a time. Requests are accepted only in IDLE, when req_valid[n] && req_ready[n].
- Arbitration (IDLE):
  - If exactly one port is valid, that port is granted.
  - If both are valid, grant the port != last_grant.
  - last_grant updates on accept.
  - Request fields are latched on accept; the requester may change them afterwards.
- Error check on the latched request. An error is any of:
  - size == 3;
  - half with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[WIDTH-1:2] >= MEM_WORDS.
  An error moves the FSM to RESP with rsp_err=1 and no memory access.
- FSM states: IDLE, RD, MERGE, WR, RESP.
  - Load: IDLE(T, accept) -> RD(T+1: mem_addr driven, mem_wr=0) -> MERGE(T+2: extract lane from mem_rdata and register the result) -> RESP(T+3: rsp_valid pulse) -> IDLE.
  - Word store: IDLE(T) -> WR(T+1: mem_wr=1, mem_wdata=wdata) -> RESP(T+2).
  - Byte/half store: IDLE(T) -> RD(T+1) -> MERGE(T+2: register mem_rdata with the target lane replaced) -> WR(T+3) -> RESP(T+4).
  - Error: IDLE(T) -> RESP(T+1).
- Lane rules, little-endian:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads: sign-extend from bit 7 or 15 unless unsigned; word loads ignore unsigned.
  - Stores: use wdata[7:0] or wdata[15:0] only.
- mem_wr is high only in WR, for exactly one cycle. mem_addr holds the latched word index from RD through WR. Outside RD/WR, mem_addr=0 and mem_wdata=0.
- rsp_valid is asserted only on the granted port's bit. rsp_rdata and rsp_err are registered and cleared to 0 in the cycle after RESP.
- Response back-to-back: a new accept may occur in the IDLE cycle immediately following RESP.
- Asynchronous reset mid-transaction: return to IDLE, and mem_wr drops immediately.
  - No response is issued for the aborted request.
  - A half-completed RMW leaves memory unmodified, because the write occurs only in WR.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - the FSM state encoding;
  - port indices PORT_CORE=0, PORT_DMA=1.
- One combinational sub-module, dmem_lane_fmt: inputs are word, addr[1:0], size, unsigned and wdata; outputs are the extracted load value and the merged store word. It is shared by MERGE for both the load and the RMW path.

Test Plan:
- Port 0 SW addr 0x10, wdata 0xDEADBEEF -> mem_wr=1 at T+1 with mem_addr=4; rsp_valid[0] at T+2 with rsp_err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF at T+3.
- Word 4 = 0xDEADBEEF; SB addr 0x11, wdata 0x55 -> RD at T+1, WR at T+3 with mem_wdata=0xDEAD55EF, rsp at T+4. LB 0x11 -> 0x00000055. LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
- LH addr 0x13 -> rsp_err=1 at T+1 with no mem_wr. LW addr 0x1000 (word index 1024, out of range) -> rsp_err=1.
- Both ports valid continuously, each issuing LW -> grants alternate 0,1,0,1; each port receives its own rsp_valid bit; the port not granted sees req_ready=0.
- SH addr 0x22 in flight, reset asserted at the MERGE cycle -> busy=0, mem_wr=0 immediately, no rsp_valid. A subsequent LW 0x20 returns the prior contents unchanged.
- Port 1 back-to-back SW requests -> the second accept occurs in the IDLE cycle after RESP; there are exactly 3 cycles between accepts.
